// File: rtl/execute_pkg.sv
// Shared types for the EX->MEM boundary: the pipeline bundle and
// the architectural NZVC flag set.
package execute_pkg;

   localparam int SCALAR_DATA_WIDTH = 48;
   localparam int REGNUM            = 16;
   localparam int RD_WIDTH          = $clog2(REGNUM);
   localparam int STALL_CNT_WIDTH   = 16;

   typedef struct packed {
      logic                         valid;
      logic [SCALAR_DATA_WIDTH-1:0] aluOut;
      logic [SCALAR_DATA_WIDTH-1:0] storeData;
      logic [RD_WIDTH-1:0]          rd;
      logic                         regWrite;
      logic                         memRead;
      logic                         memWrite;
      logic                         isScalar;
   } ex_mem_bundle_t;

   localparam ex_mem_bundle_t BUBBLE = '0;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/condition_flags_reg.sv
// Architectural NZVC register; loads only when the enclosing
// stage commits a flag-writing instruction.
module condition_flags_reg
   import execute_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  flags_t flagsIn,
   output flags_t flags
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         flags <= '0;
      else if (load)
         flags <= flagsIn;
   end

endmodule

// File: rtl/execute_memory_register.sv
// EX->MEM pipeline register with stall/flush, NZVC ownership,
// MEM-stage forwarding taps and a saturating stall counter.
module execute_memory_register
   import execute_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         exValid,
   input  logic [SCALAR_DATA_WIDTH-1:0] exOut,
   input  logic [SCALAR_DATA_WIDTH-1:0] exStoreData,
   input  logic [RD_WIDTH-1:0]          exRd,
   input  logic                         exRegWrite,
   input  logic                         exMemRead,
   input  logic                         exMemWrite,
   input  logic                         exIsScalar,
   input  logic                         exFlagWrite,
   input  logic                         exN,
   input  logic                         exZ,
   input  logic                         exV,
   input  logic                         exC,
   output logic                         memValid,
   output logic [SCALAR_DATA_WIDTH-1:0] memAluOut,
   output logic [SCALAR_DATA_WIDTH-1:0] memStoreData,
   output logic [RD_WIDTH-1:0]          memRd,
   output logic                         memRegWrite,
   output logic                         memMemRead,
   output logic                         memMemWrite,
   output logic                         memIsScalar,
   output logic                         flagN,
   output logic                         flagZ,
   output logic                         flagV,
   output logic                         flagC,
   output logic                         fwdValid,
   output logic [RD_WIDTH-1:0]          fwdRd,
   output logic [SCALAR_DATA_WIDTH-1:0] fwdData,
   output logic [STALL_CNT_WIDTH-1:0]   stallCount
);

   ex_mem_bundle_t memQ;
   ex_mem_bundle_t memD;
   ex_mem_bundle_t exBundle;
   flags_t         flags;
   logic           flagLoad;

   always_comb begin
      exBundle           = BUBBLE;
      exBundle.valid     = 1'b1;
      exBundle.aluOut    = exOut;
      exBundle.storeData = exStoreData;
      exBundle.rd        = exRd;
      exBundle.regWrite  = exRegWrite;
      exBundle.memRead   = exMemRead;
      exBundle.memWrite  = exMemWrite;
      exBundle.isScalar  = exIsScalar;
   end

   // flush beats stall beats capture; an empty EX slot is a bubble
   always_comb begin
      memD = memQ;
      priority case (1'b1)
         flush:    memD = BUBBLE;
         stall:    memD = memQ;
         !exValid: memD = BUBBLE;
         default:  memD = exBundle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         memQ <= BUBBLE;
      else
         memQ <= memD;
   end

   assign flagLoad = exValid & exFlagWrite & ~stall & ~flush;

   condition_flags_reg uFlags (
      .clk     (clk),
      .rst     (rst),
      .load    (flagLoad),
      .flagsIn ('{n: exN, z: exZ, v: exV, c: exC}),
      .flags   (flags)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stallCount <= '0;
      else if (stall && (stallCount != '1))
         stallCount <= stallCount + STALL_CNT_WIDTH'(1);
   end

   assign memValid     = memQ.valid;
   assign memAluOut    = memQ.aluOut;
   assign memStoreData = memQ.storeData;
   assign memRd        = memQ.rd;
   assign memRegWrite  = memQ.regWrite;
   assign memMemRead   = memQ.memRead;
   assign memMemWrite  = memQ.memWrite;
   assign memIsScalar  = memQ.isScalar;

   assign flagN = flags.n;
   assign flagZ = flags.z;
   assign flagV = flags.v;
   assign flagC = flags.c;

   // loads are not forwardable: their value only exists after MEM
   assign fwdValid = memQ.valid & memQ.regWrite & ~memQ.memRead;
   assign fwdRd    = memQ.rd;
   assign fwdData  = memQ.aluOut;

endmodule

// File: tb/tb_execute_memory_register.sv
// Scoreboard bench for the EX->MEM register: directed vectors push
// expected snapshots, an independent monitor pops and compares.
module tb_execute_memory_register;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        exValid = 1'b0;
   logic [47:0] exOut = '0;
   logic [47:0] exStoreData = '0;
   logic [3:0]  exRd = '0;
   logic        exRegWrite = 1'b0;
   logic        exMemRead = 1'b0;
   logic        exMemWrite = 1'b0;
   logic        exIsScalar = 1'b0;
   logic        exFlagWrite = 1'b0;
   logic        exN = 1'b0;
   logic        exZ = 1'b0;
   logic        exV = 1'b0;
   logic        exC = 1'b0;

   logic        memValid;
   logic [47:0] memAluOut;
   logic [47:0] memStoreData;
   logic [3:0]  memRd;
   logic        memRegWrite;
   logic        memMemRead;
   logic        memMemWrite;
   logic        memIsScalar;
   logic        flagN;
   logic        flagZ;
   logic        flagV;
   logic        flagC;
   logic        fwdValid;
   logic [3:0]  fwdRd;
   logic [47:0] fwdData;
   logic [15:0] stallCount;

   execute_memory_register dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .exValid      (exValid),
      .exOut        (exOut),
      .exStoreData  (exStoreData),
      .exRd         (exRd),
      .exRegWrite   (exRegWrite),
      .exMemRead    (exMemRead),
      .exMemWrite   (exMemWrite),
      .exIsScalar   (exIsScalar),
      .exFlagWrite  (exFlagWrite),
      .exN          (exN),
      .exZ          (exZ),
      .exV          (exV),
      .exC          (exC),
      .memValid     (memValid),
      .memAluOut    (memAluOut),
      .memStoreData (memStoreData),
      .memRd        (memRd),
      .memRegWrite  (memRegWrite),
      .memMemRead   (memMemRead),
      .memMemWrite  (memMemWrite),
      .memIsScalar  (memIsScalar),
      .flagN        (flagN),
      .flagZ        (flagZ),
      .flagV        (flagV),
      .flagC        (flagC),
      .fwdValid     (fwdValid),
      .fwdRd        (fwdRd),
      .fwdData      (fwdData),
      .stallCount   (stallCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [47:0] alu;
      logic [47:0] sd;
      logic [3:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        sc;
      logic [3:0]  nzvc;
      logic        fv;
      logic [3:0]  frd;
      logic [47:0] fdata;
      logic [15:0] cnt;
   } obs_t;

   typedef struct {
      string name;
      int    due;
      obs_t  exp;
   } item_t;

   item_t q[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   event  chk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst && !stall && !flush && exValid)
         assert (!(exMemRead && exMemWrite))
            else $error("illegal load+store issued");
   end

   function automatic obs_t mk(
      input logic v, input logic [47:0] alu, input logic [47:0] sd,
      input logic [3:0] rd, input logic rw, input logic mr,
      input logic mw, input logic sc, input logic [3:0] nzvc,
      input logic [15:0] cnt);
      obs_t o;
      o.valid = v;
      o.alu   = alu;
      o.sd    = sd;
      o.rd    = rd;
      o.rw    = rw;
      o.mr    = mr;
      o.mw    = mw;
      o.sc    = sc;
      o.nzvc  = nzvc;
      o.fv    = v & rw & ~mr;
      o.frd   = rd;
      o.fdata = alu;
      o.cnt   = cnt;
      return o;
   endfunction

   function automatic obs_t bubble(input logic [3:0] nzvc,
                                   input logic [15:0] cnt);
      return mk(0, '0, '0, '0, 0, 0, 0, 0, nzvc, cnt);
   endfunction

   task automatic expectAt(input string name, input int due,
                           input obs_t e);
      item_t it;
      it.name = name;
      it.due  = due;
      it.exp  = e;
      q.push_back(it);
   endtask

   task automatic expectNext(input string name, input obs_t e);
      expectAt(name, cyc + 1, e);
   endtask

   task automatic drive(
      input logic st, input logic fl, input logic v,
      input logic [47:0] o, input logic [47:0] sd, input logic [3:0] rd,
      input logic rw, input logic mr, input logic mw, input logic sc,
      input logic fw, input logic [3:0] nzvc);
      @(negedge clk);
      stall       = st;
      flush       = fl;
      exValid     = v;
      exOut       = o;
      exStoreData = sd;
      exRd        = rd;
      exRegWrite  = rw;
      exMemRead   = mr;
      exMemWrite  = mw;
      exIsScalar  = sc;
      exFlagWrite = fw;
      {exN, exZ, exV, exC} = nzvc;
   endtask

   // monitor: compares every due expectation against the live outputs
   initial begin
      obs_t a;
      item_t it;
      forever begin
         @(posedge clk or chk);
         #2;
         while (q.size() > 0 && q[0].due <= cyc) begin
            it = q.pop_front();
            a = '{memValid, memAluOut, memStoreData, memRd, memRegWrite,
                  memMemRead, memMemWrite, memIsScalar,
                  {flagN, flagZ, flagV, flagC},
                  fwdValid, fwdRd, fwdData, stallCount};
            checks++;
            if (a !== it.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", it.name, a, it.exp);
            end
         end
      end
   end

   localparam logic [47:0] A_OUT = 48'h0000_1234_5678;
   localparam logic [47:0] A_SD  = 48'h0000_0000_AAAA;

   initial begin
      #3;
      expectAt("resetInit", -1, bubble(4'b0000, 16'h0));
      ->chk;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      drive(0, 0, 1, A_OUT, A_SD, 4'd5, 1, 0, 0, 1, 0, 4'b1000);
      expectNext("capture",
                 mk(1, A_OUT, A_SD, 4'd5, 1, 0, 0, 1, 4'b0000, 16'd0));

      for (int i = 1; i <= 3; i++) begin
         drive(1, 0, 1, 48'hDEAD_BEEF_0000 + 48'(i), 48'h0, 4'd3,
               1, 0, 0, 1, 1, 4'b0100);
         expectNext($sformatf("stallHold%0d", i),
                    mk(1, A_OUT, A_SD, 4'd5, 1, 0, 0, 1, 4'b0000,
                       16'(i)));
      end

      drive(0, 0, 1, 48'h111, 48'h0, 4'd2, 1, 0, 0, 1, 1, 4'b1001);
      expectNext("flagsSet",
                 mk(1, 48'h111, 48'h0, 4'd2, 1, 0, 0, 1, 4'b1001, 16'd3));

      drive(1, 1, 1, 48'h999, 48'h0, 4'd4, 1, 0, 0, 1, 1, 4'b0100);
      expectNext("flushStall", bubble(4'b1001, 16'd4));

      drive(0, 0, 1, 48'h0102_0304_0506, 48'hCAFE, 4'd9,
            0, 0, 1, 0, 0, 4'b0100);
      expectNext("vecStore",
                 mk(1, 48'h0102_0304_0506, 48'hCAFE, 4'd9, 0, 0, 1, 0,
                    4'b1001, 16'd4));

      drive(0, 0, 0, 48'hFFFF_FFFF_FFFF, 48'h5, 4'd15,
            1, 0, 0, 1, 1, 4'b0100);
      expectNext("invalidBubble", bubble(4'b1001, 16'd4));

      drive(0, 1, 1, 48'h777, 48'h0, 4'd6, 1, 0, 0, 1, 1, 4'b0010);
      expectNext("flushOnly", bubble(4'b1001, 16'd4));

      drive(0, 0, 1, 48'h100, 48'h0, 4'd7, 1, 1, 0, 1, 1, 4'b0010);
      expectNext("load",
                 mk(1, 48'h100, 48'h0, 4'd7, 1, 1, 0, 1, 4'b0010, 16'd4));

      drive(1, 0, 1, 48'hABC, 48'h0, 4'd1, 1, 0, 0, 1, 1, 4'b1111);
      for (int i = 1; i <= 65540; i++) begin
         if (i == 65540)
            expectNext("stallSaturate",
                       mk(1, 48'h100, 48'h0, 4'd7, 1, 1, 0, 1, 4'b0010,
                          16'hFFFF));
         @(negedge clk);
      end

      @(posedge clk);
      #4;
      rst = 1'b0;
      expectAt("resetMid", -1, bubble(4'b0000, 16'h0));
      ->chk;
      #3;

      drive(0, 0, 1, 48'h8000_0000_0001, 48'h1, 4'd15,
            1, 0, 0, 1, 1, 4'b0100);
      rst = 1'b1;
      expectNext("afterReset",
                 mk(1, 48'h8000_0000_0001, 48'h1, 4'd15, 1, 0, 0, 1,
                    4'b0100, 16'd0));

      drive(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 4'b0000);
      for (int i = 0; i < 20 && q.size() > 0; i++)
         @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
